// File: rtl/pipe_ctrl_pkg.sv
// Shared CPU pipeline-control definitions: FSM state encodings, PC source
// select codes, and the load-use compare helper used by hazard detection.
package pipe_ctrl_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_VECTOR = 2'b10
    } state_t;

    // Next-PC source select
    localparam logic [1:0] PCSEL_SEQ = 2'b00;   // sequential or branch target
    localparam logic [1:0] PCSEL_VEC = 2'b01;   // interrupt handler vector
    localparam logic [1:0] PCSEL_EPC = 2'b10;   // return address from EPC

    // Cycles spent flushing younger instructions before vectoring
    localparam logic [1:0] DRAIN_CYCLES = 2'd2;

    // A load in EX whose destination (never r0) feeds an ID-stage source
    function automatic logic load_use_hit(
        input logic       memrd,
        input logic [4:0] wa,
        input logic [4:0] rs,
        input logic [4:0] rt
    );
        return memrd && (wa != 5'd0) && ((wa == rs) || (wa == rt));
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of hazard/interrupt inputs and stage-control outputs between the
// pipeline datapath (master side) and the pipeline controller (slave side).
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    // Status from datapath
    logic       mem_stall;
    logic       ex_memrd;
    logic [4:0] ex_wa;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       br_taken;
    logic       irq;
    logic       int_en;
    logic       eret_id;

    // Controls back to datapath
    logic       pc_wr;
    logic       ifid_wr;
    logic       idex_wr;
    logic       exme_wr;
    logic       mewb_wr;
    logic       ifid_clr;
    logic       idex_clr;
    logic       exme_clr;
    logic       mewb_clr;
    logic [1:0] pc_sel;
    logic       epc_wr;
    logic       int_ack;
    logic       in_isr;

    modport master (
        output mem_stall, ex_memrd, ex_wa, id_rs, id_rt, br_taken, irq, int_en, eret_id,
        input  pc_wr, ifid_wr, idex_wr, exme_wr, mewb_wr,
        input  ifid_clr, idex_clr, exme_clr, mewb_clr,
        input  pc_sel, epc_wr, int_ack, in_isr
    );

    modport slave (
        input  mem_stall, ex_memrd, ex_wa, id_rs, id_rt, br_taken, irq, int_en, eret_id,
        output pc_wr, ifid_wr, idex_wr, exme_wr, mewb_wr,
        output ifid_clr, idex_clr, exme_clr, mewb_clr,
        output pc_sel, epc_wr, int_ack, in_isr
    );
endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use hazard detector: flags when the instruction in ID
// needs the result of a load still in EX.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       i_ex_memrd,
    input  logic [4:0] i_ex_wa,
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    output logic       o_load_use
);

    assign o_load_use = load_use_hit(i_ex_memrd, i_ex_wa, i_id_rs, i_id_rt);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stage write-enables/clears, PC source select and the
// RUN -> DRAIN -> VECTOR interrupt entry sequence. Outputs are combinational
// from the registered state, drain counter, in-handler flag and inputs.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);

    state_t     r_state;
    logic [1:0] r_cnt;
    logic       r_in_isr;

    state_t     w_next_state;
    logic [1:0] w_next_cnt;
    logic       w_next_in_isr;
    logic       w_load_use;

    logic       w_pc_wr, w_ifid_wr, w_idex_wr, w_exme_wr, w_mewb_wr;
    logic       w_ifid_clr, w_idex_clr, w_exme_clr, w_mewb_clr;
    logic [1:0] w_pc_sel;
    logic       w_epc_wr, w_int_ack;

    hazard_detect u_hazard (
        .i_ex_memrd (bus.ex_memrd),
        .i_ex_wa    (bus.ex_wa),
        .i_id_rs    (bus.id_rs),
        .i_id_rt    (bus.id_rt),
        .o_load_use (w_load_use)
    );

    // State, drain counter and in-handler flag; reset abandons any sequence
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_RUN;
            r_cnt    <= 2'd0;
            r_in_isr <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_cnt    <= w_next_cnt;
            r_in_isr <= w_next_in_isr;
        end
    end

    // Next-state and stage-control decode; a memory stall freezes everything
    always_comb begin
        w_next_state  = r_state;
        w_next_cnt    = r_cnt;
        w_next_in_isr = r_in_isr;
        w_pc_wr    = 1'b0;
        w_ifid_wr  = 1'b0;
        w_idex_wr  = 1'b0;
        w_exme_wr  = 1'b0;
        w_mewb_wr  = 1'b0;
        w_ifid_clr = 1'b0;
        w_idex_clr = 1'b0;
        w_exme_clr = 1'b0;
        w_mewb_clr = 1'b0;
        w_pc_sel   = PCSEL_SEQ;
        w_epc_wr   = 1'b0;
        w_int_ack  = 1'b0;

        if (!rst) begin
            // Hold all stages cleared while reset is low
            w_ifid_clr = 1'b1;
            w_idex_clr = 1'b1;
            w_exme_clr = 1'b1;
            w_mewb_clr = 1'b1;
        end else if (bus.mem_stall) begin
            // Frozen: defaults already hold state and deassert every control
            w_next_state = r_state;
        end else begin
            case (r_state)
                ST_RUN: begin
                    w_pc_wr   = 1'b1;
                    w_ifid_wr = 1'b1;
                    w_idex_wr = 1'b1;
                    w_exme_wr = 1'b1;
                    w_mewb_wr = 1'b1;
                    if (bus.br_taken) begin
                        // Squash wrong-path fetch/decode; also cancels load-use stall
                        w_ifid_clr = 1'b1;
                        w_idex_clr = 1'b1;
                    end else if (bus.eret_id) begin
                        w_pc_sel      = PCSEL_EPC;
                        w_ifid_clr    = 1'b1;
                        w_next_in_isr = 1'b0;
                    end else if (w_load_use) begin
                        // Hold PC and IF/ID, inject a bubble into EX
                        w_pc_wr    = 1'b0;
                        w_ifid_wr  = 1'b0;
                        w_idex_clr = 1'b1;
                    end else if (bus.irq && bus.int_en && !r_in_isr) begin
                        // Capture ID-stage PC as return point and start flushing
                        w_epc_wr     = 1'b1;
                        w_pc_wr      = 1'b0;
                        w_ifid_clr   = 1'b1;
                        w_idex_clr   = 1'b1;
                        w_next_state = ST_DRAIN;
                        w_next_cnt   = DRAIN_CYCLES;
                    end else begin
                        w_pc_sel = PCSEL_SEQ;
                    end
                end
                ST_DRAIN: begin
                    // Let older instructions retire while nothing new enters
                    w_ifid_clr = 1'b1;
                    w_idex_clr = 1'b1;
                    w_exme_wr  = 1'b1;
                    w_mewb_wr  = 1'b1;
                    if (r_cnt == 2'd1) begin
                        w_next_state = ST_VECTOR;
                        w_next_cnt   = 2'd0;
                    end else begin
                        w_next_cnt = r_cnt - 2'd1;
                    end
                end
                ST_VECTOR: begin
                    w_pc_sel      = PCSEL_VEC;
                    w_pc_wr       = 1'b1;
                    w_ifid_wr     = 1'b1;
                    w_idex_wr     = 1'b1;
                    w_exme_wr     = 1'b1;
                    w_mewb_wr     = 1'b1;
                    w_int_ack     = 1'b1;
                    w_next_in_isr = 1'b1;
                    w_next_state  = ST_RUN;
                end
                default: begin
                    w_next_state = ST_RUN;
                    w_next_cnt   = 2'd0;
                end
            endcase
        end
    end

    assign bus.pc_wr    = w_pc_wr;
    assign bus.ifid_wr  = w_ifid_wr;
    assign bus.idex_wr  = w_idex_wr;
    assign bus.exme_wr  = w_exme_wr;
    assign bus.mewb_wr  = w_mewb_wr;
    assign bus.ifid_clr = w_ifid_clr;
    assign bus.idex_clr = w_idex_clr;
    assign bus.exme_clr = w_exme_clr;
    assign bus.mewb_clr = w_mewb_clr;
    assign bus.pc_sel   = w_pc_sel;
    assign bus.epc_wr   = w_epc_wr;
    assign bus.int_ack  = w_int_ack;
    assign bus.in_isr   = r_in_isr;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: each step sets inputs, pushes
// the expected control vector to a scoreboard, then pops and compares it
// against the DUT outputs at the falling edge.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    pipe_ctrl_if bus ();

    pipe_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [13:0] v;
    } exp_t;

    exp_t sb[$];

    // {pc,ifid,idex,exme,mewb}_wr, {ifid,idex,exme,mewb}_clr, pc_sel, epc_wr, int_ack, in_isr
    function automatic logic [13:0] mk(input logic [4:0] wr, input logic [3:0] clr,
                                       input logic [1:0] sel, input logic epc,
                                       input logic ack, input logic isr);
        return {wr, clr, sel, epc, ack, isr};
    endfunction

    function automatic logic [13:0] e_rst();           return mk(5'b00000, 4'b1111, PCSEL_SEQ, 1'b0, 1'b0, 1'b0); endfunction
    function automatic logic [13:0] e_run(input logic i);   return mk(5'b11111, 4'b0000, PCSEL_SEQ, 1'b0, 1'b0, i); endfunction
    function automatic logic [13:0] e_lu(input logic i);    return mk(5'b00111, 4'b0100, PCSEL_SEQ, 1'b0, 1'b0, i); endfunction
    function automatic logic [13:0] e_br(input logic i);    return mk(5'b11111, 4'b1100, PCSEL_SEQ, 1'b0, 1'b0, i); endfunction
    function automatic logic [13:0] e_eret();          return mk(5'b11111, 4'b1000, PCSEL_EPC, 1'b0, 1'b0, 1'b1); endfunction
    function automatic logic [13:0] e_entry();         return mk(5'b01111, 4'b1100, PCSEL_SEQ, 1'b1, 1'b0, 1'b0); endfunction
    function automatic logic [13:0] e_drain();         return mk(5'b00011, 4'b1100, PCSEL_SEQ, 1'b0, 1'b0, 1'b0); endfunction
    function automatic logic [13:0] e_stall(input logic i); return mk(5'b00000, 4'b0000, PCSEL_SEQ, 1'b0, 1'b0, i); endfunction
    function automatic logic [13:0] e_vec();           return mk(5'b11111, 4'b0000, PCSEL_VEC, 1'b0, 1'b1, 1'b0); endfunction

    function automatic logic [13:0] observed();
        return {bus.pc_wr, bus.ifid_wr, bus.idex_wr, bus.exme_wr, bus.mewb_wr,
                bus.ifid_clr, bus.idex_clr, bus.exme_clr, bus.mewb_clr,
                bus.pc_sel, bus.epc_wr, bus.int_ack, bus.in_isr};
    endfunction

    // One clock cycle: expectation queued with the stimulus, checked mid-cycle
    task automatic step(input string tag, input logic [13:0] e);
        exp_t x;
        exp_t got;
        logic [13:0] obs;
        x.tag = tag;
        x.v   = e;
        sb.push_back(x);
        @(negedge clk);
        got = sb.pop_front();
        obs = observed();
        n_chk++;
        assert (obs === got.v) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", got.tag, obs, got.v);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.mem_stall = 1'b0;
        bus.ex_memrd  = 1'b0;
        bus.ex_wa     = 5'd0;
        bus.id_rs     = 5'd0;
        bus.id_rt     = 5'd0;
        bus.br_taken  = 1'b0;
        bus.irq       = 1'b0;
        bus.int_en    = 1'b0;
        bus.eret_id   = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        @(posedge clk);
        #1;
        step("reset_hold", e_rst());
        rst = 1'b1;
        step("run_idle", e_run(1'b0));

        // Load-use hazards
        bus.ex_memrd = 1'b1; bus.ex_wa = 5'd5; bus.id_rs = 5'd5; bus.id_rt = 5'd9;
        step("loaduse_rs", e_lu(1'b0));
        bus.ex_wa = 5'd0; bus.id_rs = 5'd0;
        step("loaduse_r0_nostall", e_run(1'b0));
        bus.ex_wa = 5'd7; bus.id_rs = 5'd1; bus.id_rt = 5'd7;
        step("loaduse_rt", e_lu(1'b0));
        bus.ex_memrd = 1'b0;
        step("no_load_no_stall", e_run(1'b0));

        // Branch overrides load-use
        bus.ex_memrd = 1'b1; bus.br_taken = 1'b1;
        step("branch_over_loaduse", e_br(1'b0));
        idle_inputs();

        // int_en gates interrupts
        bus.irq = 1'b1;
        step("irq_disabled", e_run(1'b0));

        // Interrupt entry; irq drops after entry and must not abort
        bus.int_en = 1'b1;
        step("int_entry_c0", e_entry());
        bus.irq = 1'b0;
        step("int_drain_c1", e_drain());
        step("int_drain_c2", e_drain());
        step("int_vector_c3", e_vec());
        step("in_isr_c4", e_run(1'b1));

        // No nesting while in handler
        bus.irq = 1'b1;
        for (int i = 0; i < 10; i++) step("no_nest", e_run(1'b1));

        // ERET returns and pending irq is taken right after
        bus.eret_id = 1'b1;
        step("eret", e_eret());
        bus.eret_id = 1'b0;
        step("int_after_eret", e_entry());
        bus.irq = 1'b0;
        step("stall_drain_c1", e_drain());
        bus.mem_stall = 1'b1;
        for (int i = 0; i < 4; i++) step("stall_in_drain", e_stall(1'b0));
        bus.mem_stall = 1'b0;
        step("stall_drain_c2", e_drain());
        step("stall_vector", e_vec());
        bus.eret_id = 1'b1;
        step("eret2", e_eret());
        bus.eret_id = 1'b0;

        // Branch wins over interrupt; interrupt follows next cycle
        bus.irq = 1'b1; bus.br_taken = 1'b1;
        step("branch_over_irq", e_br(1'b0));
        bus.br_taken = 1'b0;
        step("irq_after_branch", e_entry());
        bus.irq = 1'b0;
        step("drain_before_rst", e_drain());

        // Reset mid-drain abandons the sequence
        rst = 1'b0;
        step("rst_in_drain", e_rst());
        rst = 1'b1;
        for (int i = 0; i < 4; i++) step("post_rst_no_ack", e_run(1'b0));

        // ERET with no handler active still redirects but leaves in_isr low
        bus.eret_id = 1'b1;
        step("eret_outside_isr", mk(5'b11111, 4'b1000, PCSEL_EPC, 1'b0, 1'b0, 1'b0));
        bus.eret_id = 1'b0;
        step("final_idle", e_run(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  synchronous, active-low reset.
REQ-003 SHALL have: mem_stall  in  1  data memory not ready; freeze whole pipeline.
REQ-004 SHALL have: ex_memrd  in  1  EX-stage instruction is a load.
REQ-005 SHALL have: ex_wa  in  5  EX-stage destination register.
REQ-006 SHALL have: id_rs, id_rt  in  5 each  ID-stage source registers.
REQ-007 SHALL have: br_taken  in  1  EX-stage branch/jump resolved taken.
REQ-008 SHALL have: irq  in  1  level-sensitive external interrupt request.
REQ-009 SHALL have: int_en  in  1  CP0 status interrupt-enable bit.
REQ-010 SHALL have: eret_id  in  1  ERET decoded in ID.
REQ-011 SHALL have: pc_wr, ifid_wr, idex_wr, exme_wr, mewb_wr  out  1 each  stage write enables (WriteSig).
REQ-012 SHALL have: ifid_clr, idex_clr, exme_clr, mewb_clr  out  1 each  stage clears (ClearSig).
REQ-013 SHALL have: pc_sel  out  2  00 sequential/branch, 01 handler vector, 10 EPC.
REQ-014 SHALL have: epc_wr  out  1  capture ID-stage PC into EPC.
REQ-015 SHALL have: int_ack  out  1  one-cycle interrupt acknowledge.
REQ-016 SHALL have: in_isr  out  1  handler active; masks irq.

Function
REQ-017 All outputs SHALL be combinational from state and inputs; only state, drain counter and in_isr SHALL be registered.
REQ-018 FSM states SHALL be RUN, DRAIN, VECTOR.
REQ-019 In any state, mem_stall=1 SHALL force all *_wr=0, all *_clr=0, epc_wr=0, int_ack=0, and hold state, counter and in_isr.
REQ-020 RUN default: all *_wr=1, all *_clr=0, pc_sel=00.
REQ-021 Load-use (RUN): ex_memrd=1 and ex_wa!=0 and ex_wa equals id_rs or id_rt SHALL give pc_wr=0, ifid_wr=0, idex_clr=1.
REQ-022 Branch (RUN): br_taken=1 SHALL give ifid_clr=1, idex_clr=1, pc_wr=1; branch SHALL override load-use.
REQ-023 ERET (RUN, no branch): eret_id=1 SHALL give pc_sel=10, pc_wr=1, ifid_clr=1, and clear in_isr at the edge.
REQ-024 Interrupt entry: in RUN with irq=1, int_en=1, in_isr=0, br_taken=0, eret_id=0, no load-use, no mem_stall: epc_wr=1, pc_wr=0, ifid_clr=1, idex_clr=1; next state DRAIN with counter=2.
REQ-025 DRAIN: pc_wr=0, ifid_clr=1, idex_clr=1, exme_wr=1, mewb_wr=1; counter SHALL decrement each unstalled cycle; at counter=1 next state VECTOR.
REQ-026 VECTOR (exactly one cycle): pc_sel=01, pc_wr=1, int_ack=1, in_isr set at the edge; next state RUN.
REQ-027 Interrupt latency, irq sample to int_ack, SHALL be 3 cycles absent mem_stall.
REQ-028 irq deasserting after entry SHALL NOT abort DRAIN/VECTOR.
REQ-029 irq SHALL be ignored while in_isr=1 (no nesting); eret_id outside RUN SHALL be ignored.
REQ-030 Simultaneous br_taken and interrupt conditions: branch SHALL win; interrupt evaluated again next cycle.

Reset
REQ-031 rst=0 at a rising edge SHALL set state RUN, counter 0, in_isr 0.
REQ-032 While rst=0, outputs SHALL be: all *_wr=0, all *_clr=1, pc_sel=00, epc_wr=0, int_ack=0.
REQ-033 Reset mid-DRAIN or VECTOR SHALL abandon the sequence without int_ack.

Structure
REQ-034 State encodings and pc_sel codes (PCSEL_SEQ, PCSEL_VEC, PCSEL_EPC) SHALL live in the shared CPU definitions package.
REQ-035 Hazard detection SHALL be a sub-module hazard_detect (pure combinational, load-use compare); FSM stays in pipe_ctrl.

Verification
REQ-036 ex_memrd=1, ex_wa=5, id_rs=5 -> pc_wr=0, ifid_wr=0, idex_clr=1 one cycle; ex_wa=0 same case -> no stall.
REQ-037 br_taken=1 with concurrent load-use -> ifid_clr=1, idex_clr=1, pc_wr=1, no stall.
REQ-038 irq=1, int_en=1 at cycle 0 -> epc_wr=1 cycle 0, DRAIN cycles 1-2, int_ack=1 and pc_sel=01 cycle 3, in_isr=1 from cycle 4.
REQ-039 in_isr=1, irq=1 held 10 cycles -> no epc_wr; eret_id=1 -> pc_sel=10, in_isr=0 next cycle, interrupt then taken.
REQ-040 mem_stall=1 for 4 cycles during DRAIN -> all *_wr=0, counter held; int_ack delayed by exactly 4 cycles.
REQ-041 rst=0 asserted in DRAIN -> state RUN, all *_clr=1, no int_ack after release.
